// File: rtl/mono8_pkg.sv
// mono8_pkg
// Shared definitions for the Mono8 burst serializer and its neighbours
// (crop/normalize stage reuses the coordinate counter and these helpers).
//   PIX_W      : bits per Mono8 pixel
//   ST_*       : FSM state encodings of the serializer
//   cnt_w()    : width of a counter that spans 0..n-1 (minimum 1 bit)
package mono8_pkg;

    localparam int PIX_W = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_SOF  = 2'd1;
    localparam logic [1:0] ST_SERIALIZE = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mono8_burst_serializer_coord.sv
// pixel_coord_counter
// Column/row position of the pixel currently presented on a pixel stream.
// Column advances on en_i and wraps at N_COLS-1, bumping the row; the row
// wraps at N_ROWS-1 so the pair returns to (0,0) after the last pixel.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   en_i             advance one pixel
//   clr_i            force (0,0); wins over en_i
//   col_o, row_o     current coordinates
//   frame_last_o     current pixel is (N_ROWS-1, N_COLS-1)
module pixel_coord_counter
    import mono8_pkg::*;
#(
    parameter int N_COLS = 20,
    parameter int N_ROWS = 20,
    localparam int COL_W = cnt_w(N_COLS),
    localparam int ROW_W = cnt_w(N_ROWS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             frame_last_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o        = col_q;
    assign row_o        = row_q;
    assign frame_last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/mono8_burst_serializer.sv
// mono8_burst_serializer
// Takes Mono8 frames as PIXELS_PER_BURST-pixel AXI-Stream beats (lane 0 in
// bits [7:0]) and emits one pixel per handshake with its column/row.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   ap_start / ap_done / ap_idle   arm one frame / end pulse / idle flag
//   s_axis_*                       burst input, tuser marks start of frame
//   m_axis_*                       pixel output
//   cnt_col, cnt_row               coordinates of the pixel on m_axis_tdata
//   sof_err                        pulse on a start-of-frame anomaly
// Build option MONO8_SOF_RESYNC_EN: a mid-frame tuser beat restarts the frame
// at (0,0) with that beat. Without it the beat is streamed as ordinary data
// and only sof_err reports it.
//
// state        | meaning
// ST_IDLE      | waiting for ap_start
// ST_WAIT_SOF  | dropping beats until one carries tuser
// ST_SERIALIZE | draining the burst buffer, refilling when the last lane goes
// ST_DONE      | one-cycle ap_done after the final pixel
module mono8_burst_serializer
    import mono8_pkg::*;
#(
    parameter int IN_ROWS          = 20,
    parameter int IN_COLS          = 20,
    parameter int PIXELS_PER_BURST = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               ap_start,
    output logic                               ap_done,
    output logic                               ap_idle,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic [PIX_W*PIXELS_PER_BURST-1:0]  s_axis_tdata,
    input  logic                               s_axis_tuser,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [PIX_W-1:0]                   m_axis_tdata,
    output logic [$clog2(IN_COLS)-1:0]         cnt_col,
    output logic [$clog2(IN_ROWS)-1:0]         cnt_row,
    output logic                               sof_err
);

    localparam int IDX_W = cnt_w(PIXELS_PER_BURST);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS_PER_BURST - 1);

    logic [1:0]                              state_q, state_d;
    logic [PIXELS_PER_BURST-1:0][PIX_W-1:0]  buf_q, buf_d;
    logic [IDX_W-1:0]                        idx_q, idx_d;
    logic                                    full_q, full_d;
    logic                                    sof_err_q, sof_err_d;

    logic cnt_en, cnt_clr, frame_last;
    logic m_hs, s_hs, s_rdy, last_lane, frame_end;

    assign m_hs      = full_q && m_axis_tready;
    assign last_lane = (idx_q == IDX_LAST);
    assign frame_end = (state_q == ST_SERIALIZE) && m_hs && frame_last;

    // Refill while the last lane leaves so bursts stream without a bubble.
    always_comb begin
        s_rdy = 1'b0;
        case (state_q)
            ST_WAIT_SOF:  s_rdy = 1'b1;
            ST_SERIALIZE: s_rdy = (!full_q || (last_lane && m_hs)) && !frame_end;
            default:      s_rdy = 1'b0;
        endcase
    end

    assign s_hs = s_axis_tvalid && s_rdy;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        full_d    = full_q;
        sof_err_d = 1'b0;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ap_start) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (s_hs) begin
                    if (s_axis_tuser) begin
                        buf_d   = s_axis_tdata;
                        idx_d   = '0;
                        full_d  = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = ST_SERIALIZE;
                    end else begin
                        sof_err_d = 1'b1;
                    end
                end
            end
            ST_SERIALIZE: begin
                if (m_hs) begin
                    cnt_en = 1'b1;
                    if (frame_last) begin
                        full_d  = 1'b0;
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else if (last_lane) begin
                        full_d = 1'b0;
                        idx_d  = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                if (s_hs) begin
                    buf_d  = s_axis_tdata;
                    idx_d  = '0;
                    full_d = 1'b1;
                    if (s_axis_tuser) begin
                        sof_err_d = 1'b1;
`ifdef MONO8_SOF_RESYNC_EN
                        // Beat is only accepted once the old buffer has fully
                        // drained, so restarting just means rewinding (0,0).
                        cnt_clr = 1'b1;
`endif
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            idx_q     <= '0;
            full_q    <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            idx_q     <= idx_d;
            full_q    <= full_d;
            sof_err_q <= sof_err_d;
        end
    end

    pixel_coord_counter #(
        .N_COLS (IN_COLS),
        .N_ROWS (IN_ROWS)
    ) u_coord (
        .clk_i        (clk),
        .reset_i      (reset),
        .en_i         (cnt_en),
        .clr_i        (cnt_clr),
        .col_o        (cnt_col),
        .row_o        (cnt_row),
        .frame_last_o (frame_last)
    );

    assign s_axis_tready = s_rdy;
    assign m_axis_tvalid = full_q;
    assign m_axis_tdata  = buf_q[idx_q];
    assign ap_idle       = (state_q == ST_IDLE);
    assign ap_done       = (state_q == ST_DONE);
    assign sof_err       = sof_err_q;

endmodule

// File: tb/tb_mono8_burst_serializer.sv
module tb_mono8_burst_serializer;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int PPB  = 4;
    localparam int NPIX = ROWS * COLS;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ap_start = 1'b0;
    logic              ap_done, ap_idle;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic [8*PPB-1:0]  s_tdata = '0;
    logic              s_tuser = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [7:0]        m_tdata;
    logic [2:0]        cnt_col;
    logic [1:0]        cnt_row;
    logic              sof_err;

    always #5 clk = ~clk;

    mono8_burst_serializer #(
        .IN_ROWS          (ROWS),
        .IN_COLS          (COLS),
        .PIXELS_PER_BURST (PPB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .cnt_col       (cnt_col),
        .cnt_row       (cnt_row),
        .sof_err       (sof_err)
    );

    typedef struct {
        logic [7:0] data;
        int         col;
        int         row;
        bit         last_lane;
        bit         frame_last;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int checks = 0, errors = 0;
    int cyc = 0;
    int sof_pulses = 0, done_pulses = 0, exp_sof = 0, exp_done = 0;
    int popped = 0, first_pop_cyc = -1, last_pop_cyc = -1;
    bit bp_mode = 0, rnd_ready = 0, done_due = 0, prev_stall = 0;
    logic [7:0] prev_d;
    logic [2:0] prev_c;
    logic [1:0] prev_r;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // downstream ready: held 1, 1010 toggle, or random
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready)    m_tready = 1'($urandom_range(0, 1));
        else if (bp_mode) m_tready = ~m_tready;
        else              m_tready = 1'b1;
    end

    // monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (sof_err) sof_pulses++;
            if (ap_done) done_pulses++;
            if (done_due) begin
                check("ap_done_after_last_pixel", int'(ap_done), 1);
                done_due = 0;
            end
            if (prev_stall && m_tvalid) begin
                check("stall_data_stable", int'(m_tdata), int'(prev_d));
                check("stall_col_stable", int'(cnt_col), int'(prev_c));
                check("stall_row_stable", int'(cnt_row), int'(prev_r));
            end
            if (m_tvalid && s_tready)
                check("s_tready_with_unsent_lanes",
                      int'(m_tready && q.size() > 0 && q[0].last_lane), 1);
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got data %0d at (%0d,%0d) expected none",
                             m_tdata, cnt_col, cnt_row);
                end else begin
                    e = q.pop_front();
                    check("pixel_data", int'(m_tdata), int'(e.data));
                    check("pixel_col", int'(cnt_col), e.col);
                    check("pixel_row", int'(cnt_row), e.row);
                    popped++;
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    if (e.frame_last) done_due = 1;
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata;
            prev_c = cnt_col;
            prev_r = cnt_row;
        end
    end

    task automatic send_beat(input logic [8*PPB-1:0] d, input logic u);
        int t = 0;
        bit ok;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        @(negedge clk);
        while (!s_tready && t < 500) begin
            @(negedge clk);
            t++;
        end
        ok = s_tready;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        check("beat_accepted", int'(ok), 1);
    endtask

    // One frame: reference model places every beat at pixel position pos,
    // restarting pos at 0 on a mid-frame SOF when resync is built in.
    task automatic run_frame(input bit incr, input int drops, input int mid_sof,
                             input bit start_mid, input int reset_at);
        int pos = 0, beat = 0, acc_cyc = -1, t = 0;
        logic [8*PPB-1:0] d;
        bit u;
        exp_t x;
        popped = 0;
        first_pop_cyc = -1;
        @(posedge clk);
        #1 ap_start = 1'b1;
        @(posedge clk);
        #1 ap_start = 1'b0;
        for (int i = 0; i < drops; i++) begin
            send_beat(8*PPB'($urandom), 1'b0);
            exp_sof++;
        end
        while (pos < NPIX) begin
            u = (beat == 0) || (beat == mid_sof);
            for (int l = 0; l < PPB; l++)
                d[8*l +: 8] = incr ? 8'(beat*PPB + l) : 8'($urandom);
            if (beat != 0 && u) begin
                exp_sof++;
`ifdef MONO8_SOF_RESYNC_EN
                pos = 0;
`endif
            end
            for (int l = 0; l < PPB; l++) begin
                x.data       = d[8*l +: 8];
                x.col        = (pos + l) % COLS;
                x.row        = (pos + l) / COLS;
                x.last_lane  = (l == PPB - 1);
                x.frame_last = (pos + l == NPIX - 1);
                q.push_back(x);
            end
            if (start_mid && beat == 3) ap_start = 1'b1;
            send_beat(d, u);
            ap_start = 1'b0;
            if (beat == 0) acc_cyc = cyc;
            pos += PPB;
            beat++;
            if (reset_at > 0 && pos > reset_at) begin
                t = 0;
                while (popped < reset_at && t < 500) begin
                    @(posedge clk);
                    #1 t++;
                end
                check("reached_reset_pixel", int'(popped >= reset_at), 1);
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                q.delete();
                done_due = 0;
                reset = 1'b0;
                @(negedge clk);
                check("midreset_idle", int'(ap_idle), 1);
                check("midreset_tvalid", int'(m_tvalid), 0);
                check("midreset_col", int'(cnt_col), 0);
                check("midreset_row", int'(cnt_row), 0);
                check("midreset_no_done", done_pulses, exp_done);
                return;
            end
        end
        exp_done++;
        t = 0;
        while ((q.size() != 0 || !ap_idle) && t < 2000) begin
            @(posedge clk);
            #1 t++;
        end
        check("frame_completed", int'(t < 2000), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_after_frame", int'(ap_idle), 1);
        check("s_tready_low_after_frame", int'(s_tready), 0);
        check("done_pulse_count", done_pulses, exp_done);
        check("sof_err_count", sof_pulses, exp_sof);
        if (!bp_mode && !rnd_ready) begin
            check("first_pixel_latency", first_pop_cyc - acc_cyc, 0);
            if (mid_sof < 0)
                check("pixels_back_to_back", last_pop_cyc - first_pop_cyc, NPIX - 1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ap_idle", int'(ap_idle), 1);
        check("reset_ap_done", int'(ap_done), 0);
        check("reset_m_tvalid", int'(m_tvalid), 0);
        check("reset_s_tready", int'(s_tready), 0);
        check("reset_sof_err", int'(sof_err), 0);
        check("reset_cnt_col", int'(cnt_col), 0);
        check("reset_cnt_row", int'(cnt_row), 0);

        run_frame(1, 0, -1, 0, 0);          // straight incrementing frame
        bp_mode = 1;
        run_frame(1, 0, -1, 0, 0);          // 1010 backpressure
        bp_mode = 0;
        run_frame(0, 2, -1, 0, 0);          // two beats before SOF
        run_frame(0, 0, 2, 0, 0);           // SOF on third beat
        run_frame(1, 0, -1, 0, 10);         // reset at pixel 10
        run_frame(1, 0, -1, 0, 0);          // clean frame afterwards
        run_frame(0, 0, -1, 1, 0);          // ap_start during SERIALIZE
        rnd_ready = 1;
        for (int f = 0; f < 3; f++)
            run_frame(0, $urandom_range(0, 2), ($urandom_range(0, 1) == 1) ? 5 : -1, 0, 0);
        rnd_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mono8_burst_serializer.md
Name: mono8_burst_serializer

Overview:
- Upstream neighbour of the crop/normalize stage.
- Accepts the frame grabber's Mono8 image as wide bursts of PIXELS_PER_BURST pixels per AXI-Stream beat.
- Emits exactly one pixel per handshake, together with the pixel's column and row counters and an idle indication.
- The crop stage uses these counters to select its window and uses idle to know the frame is finished.

Parameters:
- IN_ROWS, 20, frame height in pixels.
- IN_COLS, 20, frame width in pixels; must be a multiple of PIXELS_PER_BURST.
- PIXELS_PER_BURST, 4, pixels packed per input beat; lane 0 is bits [7:0].

Ports:
- clk  in  1  single clock for the block.
- reset  in  1  synchronous, active-high.
- ap_start  in  1  arm for one frame; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse after the last pixel of the frame is handshaken out.
- ap_idle  out  1  high in IDLE.
- s_axis_tvalid  in  1  burst valid.
- s_axis_tready  out  1  burst accept.
- s_axis_tdata  in  8*PIXELS_PER_BURST  packed pixels.
- s_axis_tuser  in  1  start-of-frame; meaningful on the first beat of a frame.
- m_axis_tvalid  out  1  pixel valid.
- m_axis_tready  in  1  downstream accept.
- m_axis_tdata  out  8  current pixel.
- cnt_col  out  $clog2(IN_COLS)  column of the pixel on m_axis_tdata.
- cnt_row  out  $clog2(IN_ROWS)  row of the pixel on m_axis_tdata.
- sof_err  out  1  one-cycle pulse on a start-of-frame anomaly.

Behaviour:
- Reset values: all outputs 0 except ap_idle=1. State goes to IDLE, burst buffer is emptied, counters are 0.
- States:
  - IDLE: ap_start → WAIT_SOF.
  - WAIT_SOF:
    - s_axis_tready=1.
    - A beat with tuser=1 is loaded into the burst buffer → SERIALIZE.
    - A beat with tuser=0 is consumed and dropped, and sof_err pulses.
  - SERIALIZE: lanes drain to m_axis in order 0..PIXELS_PER_BURST-1.
  - DONE: ap_done=1 for exactly one cycle → IDLE.
- Burst buffer:
  - One PIXELS_PER_BURST×8 register plus a lane index.
  - m_axis_tdata is a registered output = buffer lane[index].
  - m_axis_tvalid=1 whenever the buffer holds a lane.
- Refill and s_axis_tready in SERIALIZE:
  - s_axis_tready = (buffer empty) OR (index==last lane AND m_axis handshake this cycle) AND the frame is not complete.
  - This allows back-to-back bursts with no bubble, giving one pixel per cycle sustained when m_axis_tready=1.
- Latency: the first pixel is valid on the cycle after the SOF beat is accepted.
- Counters:
  - cnt_col increments on each m_axis handshake.
  - At IN_COLS-1, cnt_col wraps to 0 and cnt_row increments.
  - The counters always describe the pixel currently presented.
  - The counters are held while m_axis_tready=0.
- Frame end:
  - The handshake of pixel (IN_ROWS-1, IN_COLS-1) clears the buffer and enters DONE.
  - Counters return to 0.
  - s_axis_tready stays 0 from then until the next WAIT_SOF.
- Backpressure: m_axis_tdata, cnt_col and cnt_row stay stable while tvalid=1 and tready=0 (AXI rule).
- tuser=1 on a beat inside a frame (not the first beat): behaviour is set by the optional feature below.
- ap_start while not in IDLE: ignored.
- reset mid-frame: immediate return to IDLE; no ap_done.

Optional Feature:
- Macro: MONO8_SOF_RESYNC_EN.
- Defined: a mid-frame tuser=1 beat pulses sof_err and restarts the frame.
  - Counters are forced to 0.
  - That beat is loaded as lane 0 of row 0.
  - Pixels of the aborted frame still in the buffer are discarded.
- Undefined: mid-frame tuser is ignored and the frame continues. sof_err still pulses, for visibility only.

Decomposition:
- Shared package mono8_pkg:
  - State enum (IDLE, WAIT_SOF, SERIALIZE, DONE).
  - PIX_W=8.
  - Function for counter widths.
- One natural sub-module: pixel_coord_counter. It holds the col/row counter pair with an enable, a synchronous clear and a frame_last output. The same sub-module is reusable by the crop filter.

Test Plan:
- IN_ROWS=4, IN_COLS=8, PPB=4:
  - Stimulus: ap_start, then 8 beats of an incrementing pattern, first beat with tuser=1; m_axis_tready held 1.
  - Required: 32 pixels 0..31 on consecutive cycles; (col,row) = (0,0)…(7,3); ap_done pulses one cycle after pixel 31; then ap_idle=1.
- Backpressure:
  - Stimulus: toggle m_axis_tready 1010….
  - Required: identical pixel sequence; data and counters stable during stalls; s_axis_tready never high while the buffer still holds unsent lanes.
- Missing start-of-frame:
  - Stimulus: two beats with tuser=0 before the tuser=1 beat.
  - Required: two sof_err pulses; the dropped beats never appear on m_axis.
- Mid-frame start-of-frame:
  - Stimulus: tuser=1 on beat 3.
  - Required with MONO8_SOF_RESYNC_EN: counters restart at (0,0) with that beat's pixel.
  - Required without it: counters continue (col 0, row 1) and sof_err pulses.
- Reset mid-frame:
  - Stimulus: assert reset at pixel 10, then re-run the first scenario.
  - Required: no ap_done; a clean 32-pixel frame afterwards.
- ap_start pulsed during SERIALIZE → no effect; exactly one ap_done.
